// File: rtl/lcd_fill_spi.sv
// Streams one RGB565 colour to every pixel of an SPI LCD panel:
// a 0x2C memory-write command, then PIXELS hi/lo byte pairs.
module lcd_fill_spi #(
  parameter int PIXELS  = 57600,
  parameter int CLK_DIV = 2
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [15:0] color,
  input  logic        ready,
  output logic        spi_sclk,
  output logic        spi_mosi,
  output logic        spi_cs_n,
  output logic        spi_dc,
  output logic        busy,
  output logic        done
);

  localparam int PW = $clog2(PIXELS + 1);

  typedef enum logic [2:0] {
    IDLE,
    CMD,
    PIX_HI,
    PIX_LO,
    GAP
  } state_t;

  state_t r_state;
  state_t w_next;

  logic [15:0]   r_col;
  logic [15:0]   r_pend_col;
  logic          r_pend;
  logic [7:0]    r_div;
  logic          r_half;
  logic [2:0]    r_bit;
  logic [PW-1:0] r_pix;

  logic        w_half_end;
  logic        w_bit_end;
  logic        w_byte_end;
  logic        w_last_pix;
  logic        w_req;
  logic [15:0] w_req_col;
  logic        w_enter_cmd;
  logic        w_active;
  logic [7:0]  w_byte;

  assign w_half_end = (r_div == 8'(CLK_DIV - 1));
  assign w_bit_end  = w_half_end & r_half;
  assign w_byte_end = w_bit_end & (r_bit == 3'd7);
  assign w_last_pix = (r_pix == PW'(PIXELS - 1));

  // A strobe arriving on the GAP exit cycle wins over an older pending one.
  assign w_req     = ready | r_pend;
  assign w_req_col = ready ? color : r_pend_col;

  assign w_enter_cmd = (w_next == CMD) && (r_state != CMD);

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      IDLE:   if (ready) w_next = CMD;
      CMD:    if (w_byte_end) w_next = PIX_HI;
      PIX_HI: if (w_byte_end) w_next = PIX_LO;
      PIX_LO: begin
        if (w_byte_end) begin
          w_next = w_last_pix ? GAP : PIX_HI;
        end
      end
      GAP:    if (w_bit_end) w_next = w_req ? CMD : IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) r_state <= IDLE;
    else       r_state <= w_next;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_div      <= '0;
      r_half     <= 1'b0;
      r_bit      <= '0;
      r_pix      <= '0;
      r_col      <= '0;
      r_pend     <= 1'b0;
      r_pend_col <= '0;
    end else begin
      if (r_state == IDLE) begin
        r_div  <= '0;
        r_half <= 1'b0;
        r_bit  <= '0;
      end else if (w_half_end) begin
        r_div  <= '0;
        r_half <= ~r_half;
        // GAP reuses the bit timer for its length but sends no bits.
        if (r_half && r_state != GAP) r_bit <= r_bit + 3'd1;
      end else begin
        r_div <= r_div + 8'd1;
      end

      if (w_enter_cmd) begin
        r_pix <= '0;
      end else if (r_state == PIX_LO && w_byte_end &&
                   r_pix != PW'(PIXELS)) begin
        r_pix <= r_pix + PW'(1);
      end

      if (w_enter_cmd) begin
        r_col  <= w_req_col;
        r_pend <= 1'b0;
      end else if (ready && r_state != IDLE) begin
        r_pend     <= 1'b1;
        r_pend_col <= color;
      end
    end
  end

  always_comb begin
    w_byte = 8'h00;
    unique case (1'b1)
      r_state == CMD:    w_byte = 8'h2C;
      r_state == PIX_HI: w_byte = r_col[15:8];
      r_state == PIX_LO: w_byte = r_col[7:0];
      default:           w_byte = 8'h00;
    endcase
  end

  assign w_active = (r_state == CMD) || (r_state == PIX_HI) ||
                    (r_state == PIX_LO);

  assign spi_cs_n = ~w_active;
  assign spi_dc   = (r_state == PIX_HI) || (r_state == PIX_LO);
  assign spi_sclk = w_active & r_half;
  assign spi_mosi = w_active & w_byte[~r_bit];
  assign busy     = (r_state != IDLE);
  assign done     = (r_state == GAP) && (r_div == 8'd0) && !r_half;

endmodule

// File: tb/tb_lcd_fill_spi.sv
// Directed bench for lcd_fill_spi: two instances, (PIXELS=2,CLK_DIV=1)
// and (PIXELS=1,CLK_DIV=3), with SPI byte decoders on each.
module tb_lcd_fill_spi;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  logic        a_rst, a_rdy;
  logic [15:0] a_col;
  logic        a_sclk, a_mosi, a_csn, a_dc, a_busy, a_done;

  logic        b_rst, b_rdy;
  logic [15:0] b_col;
  logic        b_sclk, b_mosi, b_csn, b_dc, b_busy, b_done;

  lcd_fill_spi #(.PIXELS(2), .CLK_DIV(1)) u_a (
    .clock(clk), .reset(a_rst), .color(a_col), .ready(a_rdy),
    .spi_sclk(a_sclk), .spi_mosi(a_mosi), .spi_cs_n(a_csn),
    .spi_dc(a_dc), .busy(a_busy), .done(a_done)
  );

  lcd_fill_spi #(.PIXELS(1), .CLK_DIV(3)) u_b (
    .clock(clk), .reset(b_rst), .color(b_col), .ready(b_rdy),
    .spi_sclk(b_sclk), .spi_mosi(b_mosi), .spi_cs_n(b_csn),
    .spi_dc(b_dc), .busy(b_busy), .done(b_done)
  );

  // SPI decoder A: bytes tagged with dc in bit 8
  logic [8:0] a_q[$];
  int         a_dn = 0;
  int         a_nb = 0;
  logic [7:0] a_sh = '0;
  logic       a_psclk = 1'b0;

  always @(negedge clk) begin
    if (a_csn !== 1'b0) begin
      a_nb = 0;
    end else if (a_sclk === 1'b1 && a_psclk !== 1'b1) begin
      a_sh = {a_sh[6:0], a_mosi};
      a_nb++;
      if (a_nb == 8) begin
        a_q.push_back({a_dc, a_sh});
        a_nb = 0;
      end
    end
    if (a_done === 1'b1) a_dn++;
    a_psclk = a_sclk;
  end

  // SPI decoder B plus phase-length and MOSI-stability tracking
  logic [8:0] b_q[$];
  int         b_dn = 0;
  int         b_nb = 0;
  logic [7:0] b_sh = '0;
  logic       b_psclk = 1'b0;
  logic       b_pmosi = 1'b0;
  logic       b_inact = 1'b0;
  int         b_run = 0;
  int         b_badrun = 0;
  int         b_phases = 0;
  int         b_unst = 0;

  always @(negedge clk) begin
    if (b_csn !== 1'b0) begin
      b_nb = 0;
    end else if (b_sclk === 1'b1 && b_psclk !== 1'b1) begin
      b_sh = {b_sh[6:0], b_mosi};
      b_nb++;
      if (b_nb == 8) begin
        b_q.push_back({b_dc, b_sh});
        b_nb = 0;
      end
    end
    if (b_done === 1'b1) b_dn++;
    if (b_csn === 1'b0) begin
      if (b_inact && b_sclk === b_psclk) begin
        b_run++;
      end else begin
        if (b_inact) begin
          b_phases++;
          if (b_run != 3) b_badrun++;
        end
        b_run = 1;
      end
      if (b_inact && b_sclk === 1'b1 && b_mosi !== b_pmosi) b_unst++;
      b_inact = 1'b1;
    end else begin
      if (b_inact) begin
        b_phases++;
        if (b_run != 3) b_badrun++;
      end
      b_inact = 1'b0;
    end
    b_psclk = b_sclk;
    b_pmosi = b_mosi;
  end

  task automatic strobe_a(input logic [15:0] c);
    a_col = c;
    a_rdy = 1'b1;
    @(negedge clk);
    a_rdy = 1'b0;
  endtask

  task automatic test_reset;
    a_rst = 1'b1; b_rst = 1'b1;
    a_rdy = 1'b0; b_rdy = 1'b0;
    a_col = '0;   b_col = '0;
    repeat (3) @(negedge clk);
    n_vec++;
    if ({a_sclk, a_mosi, a_csn, a_dc, a_busy, a_done} !== 6'b001000) begin
      n_err++;
      $display("FAIL reset_a sclk/mosi/csn/dc/busy/done got %b want 001000",
               {a_sclk, a_mosi, a_csn, a_dc, a_busy, a_done});
    end
    n_vec++;
    if ({b_sclk, b_mosi, b_csn, b_dc, b_busy, b_done} !== 6'b001000) begin
      n_err++;
      $display("FAIL reset_b sclk/mosi/csn/dc/busy/done got %b want 001000",
               {b_sclk, b_mosi, b_csn, b_dc, b_busy, b_done});
    end
    a_rst = 1'b0; b_rst = 1'b0;
    repeat (2) @(negedge clk);
    n_vec++;
    if ({a_csn, a_busy, b_csn, b_busy} !== 4'b1010) begin
      n_err++;
      $display("FAIL idle_after_reset got %b want 1010",
               {a_csn, a_busy, b_csn, b_busy});
    end
  endtask

  task automatic test_basic;
    int base, d0, c;
    logic [8:0] e[5];
    logic [8:0] got;
    e = '{9'h02C, 9'h1F8, 9'h101, 9'h1F8, 9'h101};
    base = a_q.size();
    d0 = a_dn;
    strobe_a(16'hF801);
    n_vec++;
    if ({a_csn, a_dc, a_busy, a_sclk} !== 4'b0010) begin
      n_err++;
      $display("FAIL basic_cmd_entry csn/dc/busy/sclk got %b want 0010",
               {a_csn, a_dc, a_busy, a_sclk});
    end
    c = 0;
    while (a_done !== 1'b1 && c < 300) begin
      @(negedge clk);
      c++;
    end
    n_vec++;
    if (c != 80) begin
      n_err++;
      $display("FAIL basic_done_cycle got %0d want 80", c);
    end
    n_vec++;
    if ({a_csn, a_sclk, a_mosi} !== 3'b100) begin
      n_err++;
      $display("FAIL basic_gap_lines csn/sclk/mosi got %b want 100",
               {a_csn, a_sclk, a_mosi});
    end
    @(negedge clk);
    n_vec++;
    if (a_busy !== 1'b1 || a_done !== 1'b0) begin
      n_err++;
      $display("FAIL basic_gap2 busy/done got %b%b want 10", a_busy, a_done);
    end
    @(negedge clk);
    n_vec++;
    if (a_busy !== 1'b0) begin
      n_err++;
      $display("FAIL basic_busy_low got %b want 0", a_busy);
    end
    repeat (3) @(negedge clk);
    n_vec++;
    if (a_q.size() - base != 5) begin
      n_err++;
      $display("FAIL basic_nbytes got %0d want 5", a_q.size() - base);
    end
    for (int i = 0; i < 5; i++) begin
      got = 'x;
      if (base + i < a_q.size()) got = a_q[base + i];
      n_vec++;
      if (got !== e[i]) begin
        n_err++;
        $display("FAIL basic_byte%0d dc+byte got %h want %h", i, got, e[i]);
      end
    end
    n_vec++;
    if (a_dn - d0 != 1) begin
      n_err++;
      $display("FAIL basic_done_count got %0d want 1", a_dn - d0);
    end
  endtask

  task automatic test_pending;
    int base, d0, c, nd, bl;
    logic [8:0] e[10];
    logic [8:0] got;
    e = '{9'h02C, 9'h112, 9'h134, 9'h112, 9'h134,
          9'h02C, 9'h100, 9'h11F, 9'h100, 9'h11F};
    base = a_q.size();
    d0 = a_dn;
    strobe_a(16'h1234);
    repeat (20) @(negedge clk);
    strobe_a(16'h07E0);
    repeat (10) @(negedge clk);
    strobe_a(16'h001F);
    c = 0; nd = 0; bl = 0;
    while (c < 400) begin
      @(negedge clk);
      c++;
      if (a_done === 1'b1) nd++;
      if (nd < 2 && a_busy !== 1'b1) bl++;
      if (nd == 2 && a_busy === 1'b0) break;
    end
    n_vec++;
    if (nd != 2 || a_busy !== 1'b0) begin
      n_err++;
      $display("FAIL pend_finish dones=%0d busy=%b want 2 and 0",
               nd, a_busy);
    end
    n_vec++;
    if (bl != 0) begin
      n_err++;
      $display("FAIL pend_busy_gap busy-low cycles got %0d want 0", bl);
    end
    repeat (3) @(negedge clk);
    n_vec++;
    if (a_q.size() - base != 10) begin
      n_err++;
      $display("FAIL pend_nbytes got %0d want 10", a_q.size() - base);
    end
    for (int i = 0; i < 10; i++) begin
      got = 'x;
      if (base + i < a_q.size()) got = a_q[base + i];
      n_vec++;
      if (got !== e[i]) begin
        n_err++;
        $display("FAIL pend_byte%0d dc+byte got %h want %h", i, got, e[i]);
      end
    end
    n_vec++;
    if (a_dn - d0 != 2) begin
      n_err++;
      $display("FAIL pend_done_count got %0d want 2", a_dn - d0);
    end
  endtask

  task automatic test_back_to_back;
    int base, d0, c;
    logic [8:0] e[10];
    logic [8:0] got;
    e = '{9'h02C, 9'h1AA, 9'h1AA, 9'h1AA, 9'h1AA,
          9'h02C, 9'h155, 9'h155, 9'h155, 9'h155};
    base = a_q.size();
    d0 = a_dn;
    strobe_a(16'hAAAA);
    repeat (81) @(negedge clk);
    n_vec++;
    if (a_busy !== 1'b1 || a_csn !== 1'b1) begin
      n_err++;
      $display("FAIL b2b_last_gap busy/csn got %b%b want 11", a_busy, a_csn);
    end
    strobe_a(16'h5555);
    n_vec++;
    if ({a_busy, a_csn, a_dc} !== 3'b100) begin
      n_err++;
      $display("FAIL b2b_restart busy/csn/dc got %b want 100",
               {a_busy, a_csn, a_dc});
    end
    c = 0;
    while (a_busy !== 1'b0 && c < 300) begin
      @(negedge clk);
      c++;
    end
    n_vec++;
    if (c != 82) begin
      n_err++;
      $display("FAIL b2b_second_len got %0d want 82", c);
    end
    repeat (2) @(negedge clk);
    for (int i = 0; i < 10; i++) begin
      got = 'x;
      if (base + i < a_q.size()) got = a_q[base + i];
      n_vec++;
      if (got !== e[i]) begin
        n_err++;
        $display("FAIL b2b_byte%0d dc+byte got %h want %h", i, got, e[i]);
      end
    end
    n_vec++;
    if (a_dn - d0 != 2) begin
      n_err++;
      $display("FAIL b2b_done_count got %0d want 2", a_dn - d0);
    end
  endtask

  task automatic test_reset_mid;
    int base, d0, c;
    logic [8:0] e[5];
    logic [8:0] got;
    e = '{9'h02C, 9'h10F, 9'h10F, 9'h10F, 9'h10F};
    d0 = a_dn;
    strobe_a(16'hF801);
    repeat (40) @(negedge clk);
    n_vec++;
    if ({a_csn, a_dc} !== 2'b01) begin
      n_err++;
      $display("FAIL rmid_in_pixlo csn/dc got %b want 01", {a_csn, a_dc});
    end
    a_rst = 1'b1;
    @(negedge clk);
    a_rst = 1'b0;
    n_vec++;
    if ({a_csn, a_sclk, a_busy, a_mosi} !== 4'b1000) begin
      n_err++;
      $display("FAIL rmid_abort csn/sclk/busy/mosi got %b want 1000",
               {a_csn, a_sclk, a_busy, a_mosi});
    end
    repeat (90) @(negedge clk);
    n_vec++;
    if (a_dn - d0 != 0) begin
      n_err++;
      $display("FAIL rmid_no_done got %0d want 0", a_dn - d0);
    end
    base = a_q.size();
    strobe_a(16'h0F0F);
    n_vec++;
    if ({a_csn, a_dc, a_busy} !== 3'b001) begin
      n_err++;
      $display("FAIL rmid_restart csn/dc/busy got %b want 001",
               {a_csn, a_dc, a_busy});
    end
    c = 0;
    while (a_done !== 1'b1 && c < 300) begin
      @(negedge clk);
      c++;
    end
    n_vec++;
    if (c != 80) begin
      n_err++;
      $display("FAIL rmid_done_cycle got %0d want 80", c);
    end
    repeat (4) @(negedge clk);
    for (int i = 0; i < 5; i++) begin
      got = 'x;
      if (base + i < a_q.size()) got = a_q[base + i];
      n_vec++;
      if (got !== e[i]) begin
        n_err++;
        $display("FAIL rmid_byte%0d dc+byte got %h want %h", i, got, e[i]);
      end
    end
  endtask

  task automatic test_clkdiv_pix1;
    int base, d0, p0, c;
    logic [8:0] e[3];
    logic [8:0] got;
    e = '{9'h02C, 9'h1C3, 9'h1A5};
    base = b_q.size();
    d0 = b_dn;
    p0 = b_phases;
    b_col = 16'hC3A5;
    b_rdy = 1'b1;
    @(negedge clk);
    b_rdy = 1'b0;
    c = 0;
    while (b_done !== 1'b1 && c < 400) begin
      @(negedge clk);
      c++;
    end
    n_vec++;
    if (c != 144) begin
      n_err++;
      $display("FAIL div3_done_cycle got %0d want 144", c);
    end
    repeat (5) @(negedge clk);
    n_vec++;
    if (b_busy !== 1'b1 || b_csn !== 1'b1) begin
      n_err++;
      $display("FAIL div3_gap_end busy/csn got %b%b want 11", b_busy, b_csn);
    end
    @(negedge clk);
    n_vec++;
    if (b_busy !== 1'b0) begin
      n_err++;
      $display("FAIL div3_busy_low got %b want 0", b_busy);
    end
    repeat (3) @(negedge clk);
    n_vec++;
    if (b_q.size() - base != 3) begin
      n_err++;
      $display("FAIL div3_nbytes got %0d want 3", b_q.size() - base);
    end
    for (int i = 0; i < 3; i++) begin
      got = 'x;
      if (base + i < b_q.size()) got = b_q[base + i];
      n_vec++;
      if (got !== e[i]) begin
        n_err++;
        $display("FAIL div3_byte%0d dc+byte got %h want %h", i, got, e[i]);
      end
    end
    n_vec++;
    if (b_dn - d0 != 1) begin
      n_err++;
      $display("FAIL div3_done_count got %0d want 1", b_dn - d0);
    end
    n_vec++;
    if (b_phases - p0 != 48 || b_badrun != 0) begin
      n_err++;
      $display("FAIL div3_phases count=%0d bad=%0d want 48 and 0",
               b_phases - p0, b_badrun);
    end
    n_vec++;
    if (b_unst != 0) begin
      n_err++;
      $display("FAIL div3_mosi_stable changes-while-high got %0d want 0",
               b_unst);
    end
  endtask

  initial begin
    a_rst = 1'b1; b_rst = 1'b1;
    a_rdy = 1'b0; b_rdy = 1'b0;
    a_col = '0;   b_col = '0;
    @(negedge clk);
    test_reset();
    test_basic();
    repeat (4) @(negedge clk);
    test_pending();
    repeat (4) @(negedge clk);
    test_back_to_back();
    repeat (4) @(negedge clk);
    test_reset_mid();
    repeat (4) @(negedge clk);
    test_clkdiv_pix1();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/lcd_fill_spi.md
LCD_FILL_SPI -- requirements
Module: lcd_fill_spi

Interface
REQ-001 The block SHALL have parameter PIXELS, default 57600, giving the pixel count per fill (240x240 panel); legal range 1..2^20.
REQ-002 The block SHALL have parameter CLK_DIV, default 2, giving the SCLK half-period in clock cycles; legal range 1..255.
REQ-003 Port clock, input, 1: sole clock; all logic on its rising edge.
REQ-004 Port reset, input, 1: synchronous, active-high reset.
REQ-005 Port color, input, 16: RGB565 fill colour from the colour-select stage; sampled only when ready=1.
REQ-006 Port ready, input, 1: single-cycle strobe meaning color is a new fill request.
REQ-007 Port spi_sclk, output, 1: SPI clock, mode 0 (idle low, data sampled by panel on rising edge).
REQ-008 Port spi_mosi, output, 1: SPI data, MSB first.
REQ-009 Port spi_cs_n, output, 1: panel chip select, active low.
REQ-010 Port spi_dc, output, 1: data/command select; 0=command byte, 1=pixel data.
REQ-011 Port busy, output, 1: high from the cycle after a fill is accepted until the cycle GAP exits.
REQ-012 Port done, output, 1: one-cycle pulse when the last pixel bit completes.

Function
REQ-013 The FSM SHALL use states IDLE, CMD, PIX_HI, PIX_LO, GAP.
REQ-014 In IDLE with ready=1 at cycle N, the block SHALL latch color and at N+1 enter CMD with spi_cs_n=0, spi_dc=0, busy=1.
REQ-015 CMD SHALL shift out byte 0x2C (memory write); PIX_HI SHALL shift out latched color[15:8]; PIX_LO SHALL shift out color[7:0], both with spi_dc=1.
REQ-016 Each bit SHALL occupy 2*CLK_DIV cycles: spi_mosi valid and spi_sclk=0 for the first CLK_DIV cycles, spi_sclk=1 for the next CLK_DIV; spi_mosi changes only while spi_sclk=0.
REQ-017 One byte SHALL take exactly 16*CLK_DIV cycles; byte transitions SHALL have no idle cycles between them.
REQ-018 Transitions SHALL be CMD->PIX_HI, PIX_HI->PIX_LO, PIX_LO->PIX_HI while fewer than PIXELS pixels are sent, and PIX_LO->GAP after pixel PIXELS.
REQ-019 The pixel counter SHALL be $clog2(PIXELS+1) bits wide, clear on entering CMD, and increment at the end of each PIX_LO byte; it SHALL never wrap.
REQ-020 done SHALL pulse in the cycle GAP is entered; spi_cs_n SHALL go 1 and spi_sclk 0 in that same cycle.
REQ-021 GAP SHALL last 2*CLK_DIV cycles with spi_cs_n=1, then return to IDLE (busy=0); total fill time is (1+2*PIXELS)*16*CLK_DIV+2*CLK_DIV cycles after acceptance.
REQ-022 A ready strobe while busy=1 SHALL be stored in a one-deep pending register; a later strobe overwrites it (latest colour wins).
REQ-023 On GAP exit with a pending request, the block SHALL go directly to CMD using the pending colour and clear pending; busy SHALL stay 1 throughout.
REQ-024 A ready strobe in the same cycle GAP exits SHALL be treated as pending, not lost.
REQ-025 The latched colour for an in-progress fill SHALL not change until that fill completes.
REQ-026 Outside CMD/PIX_HI/PIX_LO, spi_mosi SHALL be 0 and spi_sclk 0.

Reset
REQ-027 While reset=1 the block SHALL enter IDLE and drive spi_sclk=0, spi_mosi=0, spi_cs_n=1, spi_dc=0, busy=0, done=0.
REQ-028 Reset SHALL clear the latched colour, pending flag, pixel counter, bit counter and divider counter.
REQ-029 Reset asserted mid-fill SHALL abort the transfer, with spi_cs_n=1 on the cycle after reset is sampled; no done pulse is issued.

Verification
REQ-030 PIXELS=2, CLK_DIV=1, ready with color=16'hF801 -> bytes 2C,F8,01,F8,01 on MOSI; dc 0 for byte 1 and 1 after; done after 80 cycles; busy low 2 cycles later.
REQ-031 CLK_DIV=3 -> each SCLK high and low phase is 3 cycles; MOSI is stable across every rising SCLK edge.
REQ-032 During a fill, strobe 07E0 then 001F -> after GAP, second fill sends 001F only; exactly two done pulses.
REQ-033 Strobe ready in the cycle GAP exits -> new fill starts with no extra IDLE cycle and busy stays 1.
REQ-034 Assert reset at a PIX_LO midpoint -> next cycle cs_n=1, sclk=0, busy=0, no done; next ready starts a clean 0x2C command.
REQ-035 PIXELS=1 -> exactly 3 bytes (2C, hi, lo) with a single done pulse.
